// File: rtl/pixel_wb_pkg.sv
// Shared types and default widths for the pixel write-back block.
package pixel_wb_pkg;
  localparam int PIX_W_DEF   = 12;
  localparam int ADDR_W_DEF  = 12;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;
endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read-first read port.
module frame_ram #(
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [PIX_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [PIX_W-1:0]  o_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rdata;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Non-blocking read of the array gives old data on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/pixel_writeback.sv
// Commits each finished pixel into a frame buffer when the pixel counter advances.
// Optional sequence checking is enabled with `define PIXEL_WRITEBACK_SEQ_CHECK_EN.
module pixel_writeback
  import pixel_wb_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LAST_INDEX = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic [ADDR_W-1:0]      index_in,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [PIX_W-1:0]       rd_data,
  output logic                   frame_done,
  output logic                   frame_valid,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   commit,
`ifdef PIXEL_WRITEBACK_SEQ_CHECK_EN
  output logic                   seq_err,
  output logic [ADDR_W-1:0]      seq_err_index,
`endif
  output state_t                 dbg_state
);
  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_W-1:0]      r_index_q;
  logic [PIX_W-1:0]       r_pix_q;
  logic                   r_commit;
  logic                   r_frame_done;
  logic                   r_frame_valid;
  logic [FRAME_CNT_W-1:0] r_frame_count;
  logic                   w_change;
  logic                   w_write;
  logic                   w_last;

  assign w_change = (index_in != r_index_q);
  // Write uses the pixel sampled before the counter moved, so a same-edge pixel update cannot race it.
  assign w_write  = (r_state == CAPTURE) && w_change && !rst;
  assign w_last   = (r_index_q == ADDR_W'(LAST_INDEX));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (index_in == '0 && r_index_q == '0) w_state_next = CAPTURE;
      CAPTURE: w_state_next = CAPTURE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_index_q     <= '0;
      r_pix_q       <= '0;
      r_commit      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_index_q    <= index_in;
      r_pix_q      <= pix_in;
      r_commit     <= w_write;
      r_frame_done <= w_write && w_last;
      if (w_write && w_last) begin
        r_frame_valid <= 1'b1;
        r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
      end
    end
  end

`ifdef PIXEL_WRITEBACK_SEQ_CHECK_EN
  logic              r_seq_err;
  logic [ADDR_W-1:0] r_seq_err_index;
  logic              w_seq_bad;

  assign w_seq_bad = (r_state == CAPTURE) && w_change &&
                     (index_in != r_index_q + ADDR_W'(1));

  // Only the first offending index is kept; later errors leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_err       <= 1'b0;
      r_seq_err_index <= '0;
    end else if (w_seq_bad && !r_seq_err) begin
      r_seq_err       <= 1'b1;
      r_seq_err_index <= index_in;
    end
  end

  assign seq_err       = r_seq_err;
  assign seq_err_index = r_seq_err_index;
`endif

  frame_ram #(
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_frame_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_write),
    .i_waddr (r_index_q),
    .i_wdata (r_pix_q),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign commit      = r_commit;
  assign frame_done  = r_frame_done;
  assign frame_valid = r_frame_valid;
  assign frame_count = r_frame_count;
  assign dbg_state   = r_state;
endmodule
